instruction_fetch_unit: RTL and testbench

Requester-side fetch engine for the synchronous instruction memory. It owns the fetch PC, drives the memory address every cycle, and captures the instruction returned one cycle later into a 2-entry buffer. It hands instructions downstream over a valid/ready handshake and supports PC redirect (branch/jump) with flush of buffered and in-flight fetches.

---
 rtl/instruction_fetch_unit.sv | 85 ++++++++
 tb/tb_instruction_fetch_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch engine: owns the PC, drives the synchronous instruction memory,
// buffers returned words in a 2-entry FIFO, supports redirect with flush.
module instruction_fetch_unit #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] Instruction,
    input  logic                  Redirect,
    input  logic [ADDR_WIDTH-1:0] RedirectTarget,
    input  logic                  InstrReady,
    output logic                  InstrValid,
    output logic [DATA_WIDTH-1:0] InstrOut,
    output logic [ADDR_WIDTH-1:0] InstrPC
);

    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] inflight_pc;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] buf_data [2];
    logic [ADDR_WIDTH-1:0] buf_pc   [2];
    logic                  head;
    logic [1:0]            count;

    logic       pop;
    logic       issue;
    logic       capture;
    logic       tail;
    logic [2:0] occ;
    logic [1:0] unused_tgt;

    // Target low bits are dropped: fetches are always word aligned.
    assign unused_tgt = RedirectTarget[1:0];

    assign pop     = InstrValid & InstrReady;
    // Occupancy after this edge; issuing is safe only if that leaves a slot
    // for the word that returns one cycle later.
    assign occ     = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign issue   = !Redirect && (occ < 3'd2);
    assign capture = inflight & !Redirect;
    assign tail    = head ^ count[0];

    assign Address    = fetch_pc;
    assign InstrValid = (count != 2'd0);
    assign InstrOut   = InstrValid ? buf_data[head] : '0;
    assign InstrPC    = InstrValid ? buf_pc[head] : '0;

    // PC, in-flight tracking and FIFO pointers; redirect flushes everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            inflight_pc <= '0;
            inflight    <= 1'b0;
            head        <= 1'b0;
            count       <= 2'd0;
        end else if (Redirect) begin
            fetch_pc <= {RedirectTarget[ADDR_WIDTH-1:2], 2'b00};
            inflight <= 1'b0;
            head     <= 1'b0;
            count    <= 2'd0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + ADDR_WIDTH'(4);
            end
            if (pop) begin
                head <= ~head;
            end
            count <= count + {1'b0, capture} - {1'b0, pop};
        end
    end

    // Returning word lands at the FIFO tail; outputs mask stale contents.
    always_ff @(posedge clk) begin
        if (capture) begin
            buf_data[tail] <= Instruction;
            buf_pc[tail]   <= inflight_pc;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed stimulus with a PC scoreboard
// and an independent monitor popping expectations on each handshake.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] instr;
    logic        redir;
    logic [31:0] tgt;
    logic        ready;
    logic        valid;
    logic [31:0] iout;
    logic [31:0] ipc;

    logic        rst2;
    logic [7:0]  addr2;
    logic [31:0] instr2;
    logic        ready2;
    logic        valid2;
    logic [31:0] iout2;
    logic [7:0]  ipc2;

    int checks   = 0;
    int failures = 0;

    logic [31:0] q  [$];
    logic [7:0]  q2 [$];

    always #5 clk = ~clk;

    instruction_fetch_unit #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'h0)
    ) dut (
        .clk(clk), .rst(rst), .Address(addr), .Instruction(instr),
        .Redirect(redir), .RedirectTarget(tgt), .InstrReady(ready),
        .InstrValid(valid), .InstrOut(iout), .InstrPC(ipc)
    );

    instruction_fetch_unit #(
        .ADDR_WIDTH(8), .DATA_WIDTH(32), .RESET_PC(8'hF8)
    ) dut2 (
        .clk(clk), .rst(rst2), .Address(addr2), .Instruction(instr2),
        .Redirect(1'b0), .RedirectTarget(8'h00), .InstrReady(ready2),
        .InstrValid(valid2), .InstrOut(iout2), .InstrPC(ipc2)
    );

    // Synchronous memories: word at byte address A holds A/4.
    always @(posedge clk) begin
        instr  <= {2'b00, addr[31:2]};
        instr2 <= {26'd0, addr2[7:2]};
    end

    // Monitor for the 32-bit instance.
    always @(negedge clk) begin
        if (valid && ready) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pop pc=%h data=%h", ipc, iout);
            end else begin
                logic [31:0] e;
                e = q.pop_front();
                if (ipc !== e || iout !== {2'b00, e[31:2]}) begin
                    failures++;
                    $display("FAIL stream pc=%h data=%h expected pc=%h data=%h",
                             ipc, iout, e, {2'b00, e[31:2]});
                end
            end
        end
    end

    // Monitor for the 8-bit wrap instance.
    always @(negedge clk) begin
        if (valid2 && ready2) begin
            checks++;
            if (q2.size() == 0) begin
                failures++;
                $display("FAIL wrap_unexpected pc=%h", ipc2);
            end else begin
                logic [7:0] e;
                e = q2.pop_front();
                if (ipc2 !== e || iout2 !== {26'd0, e[7:2]}) begin
                    failures++;
                    $display("FAIL wrap pc=%h data=%h expected pc=%h data=%h",
                             ipc2, iout2, e, {26'd0, e[7:2]});
                end
            end
        end
    end

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", n, a, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_run(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) q.push_back(base + 32'(4 * i));
    endtask

    task automatic chk_reset(input string n);
        chk({n, "_addr"},  addr,  32'h0);
        chk({n, "_valid"}, {31'd0, valid}, 32'd0);
        chk({n, "_out"},   iout,  32'h0);
        chk({n, "_pc"},    ipc,   32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; ready = 1'b0; redir = 1'b0; tgt = '0;
        rst2 = 1'b0; ready2 = 1'b0;
        push_run(32'h0, 16);
        step(); step();
        chk_reset("reset");
        chk("reset2_addr", {24'd0, addr2}, 32'hF8);

        // Streaming from reset
        rst = 1'b1; ready = 1'b1;
        step();
        chk("e1_valid", {31'd0, valid}, 32'd0);
        chk("e1_addr", addr, 32'h4);
        step();
        chk("e2_valid", {31'd0, valid}, 32'd1);
        chk("e2_pc", ipc, 32'h0);
        step();
        chk("e3_pc", ipc, 32'h4);
        step();
        chk("e4_pc", ipc, 32'h8);

        // Backpressure for 5 cycles
        ready = 1'b0;
        repeat (5) step();
        chk("bp_addr", addr, 32'h10);
        chk("bp_valid", {31'd0, valid}, 32'd1);
        chk("bp_pc", ipc, 32'h8);
        ready = 1'b1;
        step();
        chk("bp_resume_pc", ipc, 32'hC);
        chk("bp_resume_addr", addr, 32'h14);
        step(); step(); step();

        // Redirect with a full buffer
        ready = 1'b0;
        step();
        chk("full_pc", ipc, 32'h18);
        chk("full_addr", addr, 32'h20);
        redir = 1'b1; tgt = 32'h43;
        step();
        chk("rd_valid", {31'd0, valid}, 32'd0);
        chk("rd_addr", addr, 32'h40);
        chk("rd_out", iout, 32'h0);
        chk("rd_pc", ipc, 32'h0);
        q.delete();
        push_run(32'h40, 16);
        redir = 1'b0; ready = 1'b1;
        step();
        chk("rd_e1_valid", {31'd0, valid}, 32'd0);
        chk("rd_e1_addr", addr, 32'h44);
        step();
        chk("rd_e2_pc", ipc, 32'h40);
        chk("rd_e2_out", iout, 32'h10);
        step(); step();
        chk("pre_rp_pc", ipc, 32'h48);

        // Redirect + pop in the same cycle, held for 3 edges
        redir = 1'b1; tgt = 32'h100;
        step();
        chk("rp_valid", {31'd0, valid}, 32'd0);
        chk("rp_addr", addr, 32'h100);
        q.delete();
        push_run(32'h100, 16);
        step();
        chk("hold1_addr", addr, 32'h100);
        step();
        chk("hold2_addr", addr, 32'h100);
        chk("hold2_valid", {31'd0, valid}, 32'd0);
        redir = 1'b0;
        step();
        chk("rp_e1_valid", {31'd0, valid}, 32'd0);
        chk("rp_e1_addr", addr, 32'h104);
        step();
        chk("rp_e2_pc", ipc, 32'h100);
        chk("rp_e2_out", iout, 32'h40);
        step(); step(); step();

        // Async reset with a full buffer
        ready = 1'b0;
        step();
        chk("pre_rst_pc", ipc, 32'h10C);
        chk("pre_rst_addr", addr, 32'h114);
        #2;
        rst = 1'b0;
        #1;
        chk_reset("async");
        q.delete();
        push_run(32'h0, 16);
        step();
        chk("in_rst_addr", addr, 32'h0);
        rst = 1'b1; ready = 1'b1;
        step();
        chk("rs_e1_addr", addr, 32'h4);
        step();
        chk("rs_e2_pc", ipc, 32'h0);
        step(); step(); step();
        ready = 1'b0;

        // Address wrap on the 8-bit instance
        q2.push_back(8'hF8);
        q2.push_back(8'hFC);
        q2.push_back(8'h00);
        q2.push_back(8'h04);
        rst2 = 1'b1; ready2 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (q2.size() == 0) break;
        end
        ready2 = 1'b0;
        chk("wrap_drained", 32'(q2.size()), 32'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
